// File: rtl/adder_tree_seq_if.sv
// Job, chunk-stream, adder-tree and result signals of the adder-tree sequencer.
interface adder_tree_seq_if #(
  parameter int N_DIM_ARRAY    = 8,
  parameter int ACC_DATA_WIDTH = 32,
  parameter int CNT_WIDTH      = 16
);
  localparam int LW = $clog2(N_DIM_ARRAY) + 1;

  // job control
  logic                                           start_i;
  logic [CNT_WIDTH-1:0]                           num_chunks_i;
  logic [LW-1:0]                                  last_lanes_i;
  logic [ACC_DATA_WIDTH-1:0]                      bias_i;
  // chunk stream; lane k sits at bits [k*W +: W]
  logic                                           in_valid_i;
  logic                                           in_ready_o;
  logic [N_DIM_ARRAY-1:0][ACC_DATA_WIDTH-1:0]     in_data_i;
  // external combinational adder tree
  logic [N_DIM_ARRAY-1:0][ACC_DATA_WIDTH-1:0]     tree_operands_o;
  logic [ACC_DATA_WIDTH-1:0]                      tree_result_i;
  // result port and status
  logic                                           out_valid_o;
  logic                                           out_ready_i;
  logic [ACC_DATA_WIDTH-1:0]                      out_data_o;
  logic                                           busy_o;
  logic                                           done_o;

  modport slave (
    input  start_i, num_chunks_i, last_lanes_i, bias_i,
    input  in_valid_i, in_data_i, tree_result_i, out_ready_i,
    output in_ready_o, tree_operands_o, out_valid_o, out_data_o, busy_o, done_o
  );

  modport master (
    output start_i, num_chunks_i, last_lanes_i, bias_i,
    output in_valid_i, in_data_i, tree_result_i, out_ready_i,
    input  in_ready_o, tree_operands_o, out_valid_o, out_data_o, busy_o, done_o
  );
endinterface

// File: rtl/adder_tree_seq.sv
// Adder-tree sequencer: streams N-lane chunks through an external adder tree
// and accumulates the tree sums onto a bias to reduce a vector to one scalar.

// Per-lane operand gate: zeroes lanes beyond the valid count of the final chunk.
module adder_tree_seq_lane #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_data,
  input  logic         i_keep,
  output logic [W-1:0] o_data
);
  assign o_data = i_keep ? i_data : '0;
endmodule

module adder_tree_seq #(
  parameter int N_DIM_ARRAY    = 8,
  parameter int ACC_DATA_WIDTH = 32,
  parameter int CNT_WIDTH      = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  adder_tree_seq_if.slave   bus
);
  localparam int W  = ACC_DATA_WIDTH;
  localparam int LW = $clog2(N_DIM_ARRAY) + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_OUTPUT} state_t;

  state_t               r_state, w_state_nxt;
  logic [CNT_WIDTH-1:0] r_num, r_cnt;
  logic [LW-1:0]        r_last;
  logic [W-1:0]         r_acc, r_out;

  logic                 w_start, w_in_ready, w_out_valid, w_busy;
  logic                 w_accept, w_final;
  logic [LW-1:0]        w_last_cfg;
  logic [W-1:0]         w_acc_sum;

  // a last_lanes of 0 means the final chunk is full
  assign w_last_cfg = (bus.last_lanes_i == '0) ? LW'(N_DIM_ARRAY) : bus.last_lanes_i;
  assign w_start    = (r_state == S_IDLE) & bus.start_i;
  assign w_final    = (r_cnt == r_num - CNT_ONE);
  assign w_accept   = bus.in_valid_i & w_in_ready;
  assign w_acc_sum  = r_acc + bus.tree_result_i;

  // lane gating is purely combinational so the tree sees valid operands every cycle
  for (genvar k = 0; k < N_DIM_ARRAY; k++) begin : g_lane
    localparam logic [LW-1:0] K = LW'(k);
    adder_tree_seq_lane #(.W(W)) u_lane (
      .i_data (bus.in_data_i[k]),
      .i_keep (~w_final | (K < r_last)),
      .o_data (bus.tree_operands_o[k])
    );
  end

  // state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // next-state and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (bus.start_i)
          w_state_nxt = (bus.num_chunks_i == '0) ? S_OUTPUT : S_ACCUM;
      end
      S_ACCUM: begin
        w_in_ready = 1'b1;
        if (bus.in_valid_i && w_final) w_state_nxt = S_OUTPUT;
      end
      S_OUTPUT: begin
        w_out_valid = 1'b1;
        if (bus.out_ready_i) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // job config latch, accumulator, chunk counter and result register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_num  <= '0;
      r_last <= '0;
      r_cnt  <= '0;
      r_acc  <= '0;
      r_out  <= '0;
    end else if (w_start) begin
      r_num  <= bus.num_chunks_i;
      r_last <= w_last_cfg;
      r_cnt  <= '0;
      r_acc  <= bus.bias_i;
      // empty job: the bias is the result
      if (bus.num_chunks_i == '0) r_out <= bus.bias_i;
    end else if (w_accept) begin
      r_acc <= w_acc_sum;
      // counter stops at num_chunks, so a full-range job never wraps
      r_cnt <= r_cnt + CNT_ONE;
      if (w_final) r_out <= w_acc_sum;
    end
  end

  assign bus.in_ready_o  = w_in_ready;
  assign bus.out_valid_o = w_out_valid;
  assign bus.out_data_o  = r_out;
  assign bus.busy_o      = w_busy;
  assign bus.done_o      = w_out_valid & bus.out_ready_i;
endmodule

// File: tb/tb_adder_tree_seq.sv
// Self-checking bench for adder_tree_seq: directed plus randomized jobs scored
// against a plain-arithmetic reduction of the chunk list.
module tb_adder_tree_seq;
  localparam int N  = 8;
  localparam int W  = 32;
  localparam int CW = 16;

  typedef logic [N-1:0][W-1:0] chunk_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;
  chunk_t chunks[$];

  always #5 clk = ~clk;

  adder_tree_seq_if #(.N_DIM_ARRAY(N), .ACC_DATA_WIDTH(W), .CNT_WIDTH(CW)) bus ();

  adder_tree_seq #(.N_DIM_ARRAY(N), .ACC_DATA_WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  // behavioural adder tree: plain sum of the presented operands
  always_comb begin
    logic [W-1:0] s;
    s = '0;
    for (int k = 0; k < N; k++) s = s + bus.tree_operands_o[k];
    bus.tree_result_i = s;
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // expected result: bias plus every lane of every chunk, final chunk truncated
  function automatic logic [W-1:0] ref_sum(input int num, input int last, input logic [W-1:0] bias);
    logic [W-1:0] s;
    int eff;
    s = bias;
    eff = (last == 0) ? N : last;
    for (int c = 0; c < num; c++)
      for (int k = 0; k < N; k++)
        if (c < num - 1 || k < eff) s = s + chunks[c][k];
    return s;
  endfunction

  function automatic chunk_t rnd_chunk();
    chunk_t ch;
    for (int k = 0; k < N; k++) ch[k] = $urandom;
    return ch;
  endfunction

  task automatic run_job(input int num, input int last, input logic [W-1:0] bias,
                         input bit gaps, input bit hold_valid, input int bp, input bit chk_ops);
    logic [W-1:0] exp;
    int eff;
    exp = ref_sum(num, last, bias);
    eff = (last == 0) ? N : last;
    @(negedge clk);
    bus.start_i      = 1'b1;
    bus.num_chunks_i = CW'(num);
    bus.last_lanes_i = 4'(last);
    bus.bias_i       = bias;
    bus.in_valid_i   = hold_valid;
    @(negedge clk);
    bus.start_i = 1'b0;
    #1;
    chk("busy_after_start", bus.busy_o, 1);
    if (num == 0) chk("no_ready_empty_job", bus.in_ready_o, 0);
    for (int c = 0; c < num; c++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        bus.in_valid_i = 1'b0;
        #1 chk("ready_in_gap", bus.in_ready_o, 1);
        @(negedge clk);
      end
      bus.in_data_i  = chunks[c];
      bus.in_valid_i = 1'b1;
      #1;
      if (chk_ops) begin
        chk("ready_accum", bus.in_ready_o, 1);
        for (int k = 0; k < N; k++)
          chk($sformatf("operand_c%0d_l%0d", c, k), bus.tree_operands_o[k],
              (c == num - 1 && k >= eff) ? '0 : chunks[c][k]);
      end
      @(negedge clk);
    end
    bus.in_valid_i = hold_valid;
    bus.in_data_i  = rnd_chunk();
    #1;
    chk("out_valid_latency", bus.out_valid_o, 1);
    chk("out_data", bus.out_data_o, exp);
    chk("ready_low_output", bus.in_ready_o, 0);
    chk("no_early_done", bus.done_o, 0);
    for (int b = 0; b < bp; b++) begin
      bus.out_ready_i = 1'b0;
      bus.start_i     = 1'b1;
      @(negedge clk);
      #1;
      chk("bp_valid", bus.out_valid_o, 1);
      chk("bp_data_stable", bus.out_data_o, exp);
      chk("bp_busy", bus.busy_o, 1);
      chk("bp_no_accept", bus.in_ready_o, 0);
    end
    bus.start_i     = 1'b0;
    bus.out_ready_i = 1'b1;
    #1 chk("done_pulse", bus.done_o, 1);
    @(negedge clk);
    bus.out_ready_i = 1'b0;
    bus.in_valid_i  = 1'b0;
    #1;
    chk("idle_busy", bus.busy_o, 0);
    chk("idle_valid", bus.out_valid_o, 0);
    chk("idle_done", bus.done_o, 0);
    chk("data_retained", bus.out_data_o, exp);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, bus.in_ready_o, 0);
    chk({tag, "_valid"}, bus.out_valid_o, 0);
    chk({tag, "_data"},  bus.out_data_o, 0);
    chk({tag, "_busy"},  bus.busy_o, 0);
    chk({tag, "_done"},  bus.done_o, 0);
  endtask

  initial begin
    chunk_t ch;
    bus.start_i      = 1'b0;
    bus.num_chunks_i = '0;
    bus.last_lanes_i = '0;
    bus.bias_i       = '0;
    bus.in_valid_i   = 1'b0;
    bus.in_data_i    = '0;
    bus.out_ready_i  = 1'b0;

    // reset state
    @(negedge clk);
    #1 chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // single chunk 1..8 plus bias 10 = 46
    chunks.delete();
    for (int k = 0; k < N; k++) ch[k] = W'(k + 1);
    chunks.push_back(ch);
    run_job(1, 8, 32'd10, 0, 0, 1, 1);
    chk("t1_value", bus.out_data_o, 32'd46);

    // three back-to-back all-ones chunks = 24, valid held high throughout
    chunks.delete();
    for (int k = 0; k < N; k++) ch[k] = 32'd1;
    repeat (3) chunks.push_back(ch);
    run_job(3, 8, 32'd0, 0, 1, 0, 1);
    chk("t2_value", bus.out_data_o, 32'd24);

    // partial final chunk: 8*5 + 3*5 = 55
    chunks.delete();
    for (int k = 0; k < N; k++) ch[k] = 32'd5;
    repeat (2) chunks.push_back(ch);
    run_job(2, 3, 32'd0, 0, 0, 0, 1);
    chk("t3_value", bus.out_data_o, 32'd55);

    // empty job returns bias -7
    chunks.delete();
    run_job(0, 8, 32'hFFFF_FFF9, 0, 1, 0, 1);
    chk("t4_value", bus.out_data_o, 32'hFFFF_FFF9);

    // signed wrap with 5 cycles of backpressure and start held during it
    chunks.delete();
    ch = '0;
    ch[0] = 32'd1;
    chunks.push_back(ch);
    run_job(1, 8, 32'h7FFF_FFFF, 0, 0, 5, 1);
    chk("t5_value", bus.out_data_o, 32'h8000_0000);

    // abort after 1 of 4 chunks: everything back to reset values, no done
    @(negedge clk);
    bus.start_i = 1'b1; bus.num_chunks_i = 16'd4; bus.last_lanes_i = 4'd8; bus.bias_i = 32'd3;
    @(negedge clk);
    bus.start_i = 1'b0; bus.in_valid_i = 1'b1; bus.in_data_i = rnd_chunk();
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk_reset_outputs("abort");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("abort_no_done", bus.done_o, 0);
      chk("abort_no_valid", bus.out_valid_o, 0);
      chk("abort_idle", bus.busy_o, 0);
    end
    bus.in_valid_i = 1'b0;
    chunks.delete();
    for (int k = 0; k < N; k++) ch[k] = 32'd2;
    chunks.push_back(ch);
    run_job(1, 8, 32'd0, 0, 0, 0, 1);
    chk("t6_value", bus.out_data_o, 32'd16);

    // randomized jobs
    for (int j = 0; j < 10; j++) begin
      int num;
      num = $urandom_range(1, 6);
      chunks.delete();
      for (int c = 0; c < num; c++) chunks.push_back(rnd_chunk());
      run_job(num, $urandom_range(0, N), $urandom, 1'($urandom), 1'($urandom),
              $urandom_range(0, 3), 1);
    end

    // full-range chunk count must complete without counter wrap
    chunks.delete();
    for (int c = 0; c < 65535; c++) chunks.push_back(rnd_chunk());
    run_job(65535, $urandom_range(1, N), $urandom, 0, 1, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
